ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter. It sends one command byte (for example 0xED for keyboard LEDs, or 0xF4 to enable) to the keyboard or mouse on the shared ps2_clk/ps2_data lines.
- It is the host-to-device direction of the existing PS/2 receive path.
- It runs on the 100 MHz system clock and drives the lines open-drain through output-enable signals. The top level ties each line to 0 when its oe is high and to Z otherwise.

---
 rtl/ps2_host_tx.sv | 333 +++++++++++++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
//
// Sends one byte (8 data bits LSB first, odd parity, stop, device ACK) to a
// PS/2 keyboard or mouse. Both lines are open-drain: the top level ties a line
// to 0 when its *_oe output is high and leaves it at Z otherwise.
//
// Optional build macro: PS2_TX_GLITCH_FILTER_EN
//   When it is defined, the synchronized ps2_clk goes through a debounce filter.
//   The filter output changes only after the new level has held for
//   FILTER_CYCLES consecutive cycles, so each edge arrives FILTER_CYCLES cycles
//   later. When it is undefined, edges come straight from the synchronizer.
//
// Parameters:
//   INHIBIT_CYCLES  cycles ps2_clk is held low before request-to-send
//   TIMEOUT_CYCLES  watchdog limit counted from clock release to end of ACK
//   FILTER_CYCLES   stable cycles the ps2_clk filter requires
//
// Ports:
//   clk_i            system clock
//   reset_i          asynchronous active-high reset
//   tx_data_i        byte to send
//   tx_valid_i       send request; the byte is accepted when tx_valid_i && tx_ready_o
//   tx_ready_o       high only when idle
//   ps2_clk_in_i     level sampled at the ps2_clk pad
//   ps2_data_in_i    level sampled at the ps2_data pad
//   ps2_clk_oe_o     1 pulls ps2_clk low
//   ps2_data_oe_o    1 pulls ps2_data low
//   busy_o           high whenever a transfer is in progress
//   tx_done_o        one-cycle pulse after the device ACKs
//   tx_error_o       one-cycle pulse on NACK or watchdog timeout

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_CYCLES  = 8
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    input  logic       ps2_clk_in_i,
    input  logic       ps2_data_in_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_data_oe_o,
    output logic       busy_o,
    output logic       tx_done_o,
    output logic       tx_error_o
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [IW-1:0] INH_MAX  = IW'(INHIBIT_CYCLES);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT_CYCLES);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_ACK,
        S_WAIT_IDLE,
        S_ERROR
    } state_t;

    // ------------------------------------------------------------------
    // Pad synchronizers. They reset to 1 (idle bus level) so that leaving
    // reset can never look like a falling edge.
    // ------------------------------------------------------------------
    logic [1:0] clk_sync_q;
    logic [1:0] data_sync_q;
    logic       clk_s;
    logic       data_s;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in_i};
            data_sync_q <= {data_sync_q[0], ps2_data_in_i};
        end
    end

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];

    // ------------------------------------------------------------------
    // Clock level used for edge detection (optionally debounced)
    // ------------------------------------------------------------------
    logic clk_lvl;

`ifdef PS2_TX_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_CYCLES - 1);

    logic          flt_q;
    logic          flt_d;
    logic [FW-1:0] fcnt_q;
    logic [FW-1:0] fcnt_d;

    // fcnt counts consecutive cycles on which the input differs from the
    // filtered level; any cycle that agrees restarts the count.
    always_comb begin
        flt_d  = flt_q;
        fcnt_d = '0;
        if (clk_s != flt_q) begin
            if (fcnt_q >= FLT_LAST) begin
                flt_d  = clk_s;
                fcnt_d = '0;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            flt_q  <= 1'b1;
            fcnt_q <= '0;
        end else begin
            flt_q  <= flt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign clk_lvl = flt_q;
`else
    logic unused_filter;
    assign unused_filter = ^FILTER_CYCLES;
    assign clk_lvl       = clk_s;
`endif

    logic clk_prev_q;
    logic clk_fall;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            clk_prev_q <= 1'b1;
        end else begin
            clk_prev_q <= clk_lvl;
        end
    end

    assign clk_fall = clk_prev_q & ~clk_lvl;

    // ------------------------------------------------------------------
    // Transfer FSM
    // ------------------------------------------------------------------
    state_t        state_q,   state_d;
    logic [7:0]    shreg_q,   shreg_d;
    logic          par_q,     par_d;
    logic [3:0]    bitcnt_q,  bitcnt_d;
    logic [IW-1:0] inh_q,     inh_d;
    logic [WW-1:0] wd_q,      wd_d;
    logic          clk_oe_q,  clk_oe_d;
    logic          data_oe_q, data_oe_d;
    logic          done_q,    done_d;
    logic          err_q,     err_d;
    logic          ok_q,      ok_d;
    logic          wd_active;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            bitcnt_q  <= '0;
            inh_q     <= '0;
            wd_q      <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ok_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            bitcnt_q  <= bitcnt_d;
            inh_q     <= inh_d;
            wd_q      <= wd_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ok_q      <= ok_d;
        end
    end

    assign wd_active = (state_q == S_RTS)    || (state_q == S_DATA) ||
                       (state_q == S_PARITY) || (state_q == S_STOP) ||
                       (state_q == S_ACK)    || (state_q == S_WAIT_IDLE);

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        bitcnt_d  = bitcnt_q;
        inh_d     = inh_q;
        wd_d      = wd_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        ok_d      = ok_q;

        if (wd_active && (wd_q != WD_MAX)) begin
            wd_d = wd_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (tx_valid_i) begin
                    shreg_d   = tx_data_i;
                    par_d     = ~^tx_data_i;
                    bitcnt_d  = '0;
                    inh_d     = '0;
                    ok_d      = 1'b0;
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
                    state_d   = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                if (inh_q >= INH_LAST) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    wd_d      = '0;
                    state_d   = S_RTS;
                end else if (inh_q != INH_MAX) begin
                    inh_d = inh_q + 1'b1;
                end
            end

            // The first falling edge after release already carries bit 0,
            // so it is put out here rather than one edge later.
            S_RTS: begin
                if (clk_fall) begin
                    data_oe_d = ~shreg_q[0];
                    shreg_d   = {1'b0, shreg_q[7:1]};
                    bitcnt_d  = 4'd1;
                    state_d   = S_DATA;
                end
            end

            S_DATA: begin
                if (clk_fall) begin
                    data_oe_d = ~shreg_q[0];
                    shreg_d   = {1'b0, shreg_q[7:1]};
                    if (bitcnt_q != 4'd8) begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                    if (bitcnt_q == 4'd7) begin
                        state_d = S_PARITY;
                    end
                end
            end

            S_PARITY: begin
                if (clk_fall) begin
                    data_oe_d = ~par_q;
                    state_d   = S_STOP;
                end
            end

            S_STOP: begin
                if (clk_fall) begin
                    data_oe_d = 1'b0;
                    state_d   = S_ACK;
                end
            end

            S_ACK: begin
                if (clk_fall) begin
                    if (!data_s) begin
                        ok_d    = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end else begin
                        clk_oe_d  = 1'b0;
                        data_oe_d = 1'b0;
                        state_d   = S_ERROR;
                    end
                end
            end

            // Extra clock edges here are ignored; only the idle bus matters.
            S_WAIT_IDLE: begin
                if (clk_lvl && data_s) begin
                    done_d  = ok_q;
                    err_d   = ~ok_q;
                    state_d = S_IDLE;
                end
            end

            S_ERROR: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                err_d     = 1'b1;
                state_d   = S_IDLE;
            end

            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase

        // Watchdog expiry overrides whatever the edge logic decided this cycle.
        if (wd_active && (wd_q >= WD_LAST)) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done_d    = 1'b0;
            err_d     = 1'b0;
            state_d   = S_ERROR;
        end
    end

    assign tx_ready_o    = (state_q == S_IDLE);
    assign busy_o        = (state_q != S_IDLE);
    assign ps2_clk_oe_o  = clk_oe_q;
    assign ps2_data_oe_o = data_oe_q;
    assign tx_done_o     = done_q;
    assign tx_error_o    = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard testbench for ps2_host_tx with a PS/2 device model

module tb_ps2_host_tx;

    localparam int INH  = 200;
    localparam int TOUT = 3000;
    localparam int FLT  = 8;
    localparam int HALF = 20;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       tx_done;
    logic       tx_error;

    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;
    logic ps2_clk_line;
    logic ps2_data_line;

    // Open-drain wired-AND of host and device
    assign ps2_clk_line  = dev_clk  & ~ps2_clk_oe;
    assign ps2_data_line = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TOUT),
        .FILTER_CYCLES (FLT)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .tx_data_i    (tx_data),
        .tx_valid_i   (tx_valid),
        .tx_ready_o   (tx_ready),
        .ps2_clk_in_i (ps2_clk_line),
        .ps2_data_in_i(ps2_data_line),
        .ps2_clk_oe_o (ps2_clk_oe),
        .ps2_data_oe_o(ps2_data_oe),
        .busy_o       (busy),
        .tx_done_o    (tx_done),
        .tx_error_o   (tx_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       is_err;
        logic       chk_frame;
        logic       chk_tout;
        logic [7:0] byte_v;
        logic       par;
    } exp_t;

    exp_t sb[$];

    int n_checks  = 0;
    int n_fail    = 0;
    int n_done    = 0;
    int n_err     = 0;
    int exp_done  = 0;
    int exp_err   = 0;

    logic [7:0] cap_byte = 8'h00;
    logic       cap_par  = 1'b0;
    logic       cap_stop = 1'b0;
    int         meas_inh = 0;
    int         rts_cyc  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: pops one expectation per completion pulse
    initial begin : monitor
        logic prev_busy;
        exp_t e;
        int   d;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_busy = 1'b0;
            end else begin
                if (tx_done || tx_error) begin
                    if (tx_done) n_done++;
                    if (tx_error) n_err++;
                    chk("done_error_exclusive", {31'd0, tx_done & tx_error}, 32'd0);
                    chk("scoreboard_nonempty", {31'd0, sb.size() > 0}, 32'd1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("completion_is_error", {31'd0, tx_error}, {31'd0, e.is_err});
                        chk("lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
                        chk("ready_at_completion", {31'd0, tx_ready}, 32'd1);
                        chk("busy_falls_with_idle", {30'd0, prev_busy, busy}, 32'd2);
                        if (e.chk_frame) begin
                            chk("frame_byte", {24'd0, cap_byte}, {24'd0, e.byte_v});
                            chk("frame_parity", {31'd0, cap_par}, {31'd0, e.par});
                            chk("frame_stop", {31'd0, cap_stop}, 32'd1);
                            chk("inhibit_cycles", meas_inh, INH);
                        end
                        if (e.chk_tout) begin
                            d = cyc - rts_cyc;
                            chk("timeout_window", {31'd0, (d >= TOUT - 2) && (d <= TOUT + 2)}, 32'd1);
                        end
                    end
                end
                prev_busy = busy;
            end
        end
    end

    // Device model: requests the byte, then clocks the frame in.
    task automatic run_frame(input logic [7:0] b, input bit ack, input bit silent,
                             input int abort_k, input bit inject, input bit glitch);
        int n;
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        n = 0;
        while (ps2_clk_oe && (n < INH + 50)) begin
            @(negedge clk);
            n++;
        end
        meas_inh = n;
        rts_cyc  = cyc;
        chk("rts_clk_released", {31'd0, ps2_clk_oe}, 32'd0);
        chk("rts_start_bit", {31'd0, ps2_data_oe}, 32'd1);
        if (silent) return;
        for (int k = 1; k <= 11; k++) begin
            if ((k == 11) && ack) dev_data = 1'b0;
            if (inject && (k == 5)) begin
                tx_data  = 8'h55;
                tx_valid = 1'b1;
            end
            repeat (5) @(negedge clk);
            tx_valid = 1'b0;
            dev_clk  = 1'b0;
            if (k == abort_k) begin
                repeat (HALF / 2) @(negedge clk);
                #2 reset = 1'b1;
                #1 chk("reset_releases_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
                repeat (2) @(negedge clk);
                reset   = 1'b0;
                dev_clk = 1'b1;
                repeat (3) @(negedge clk);
                chk("ready_after_reset", {31'd0, tx_ready}, 32'd1);
                chk("idle_after_reset", {31'd0, busy}, 32'd0);
                return;
            end
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            if (k <= 8) cap_byte[k-1] = ps2_data_line;
            if (k == 9) cap_par = ps2_data_line;
            if (k == 10) cap_stop = ps2_data_line;
            if (k == 11) dev_data = 1'b1;
            if (glitch && (k == 3)) begin
                repeat (5) @(negedge clk);
                dev_clk = 1'b0;
                repeat (3) @(negedge clk);
                dev_clk = 1'b1;
                repeat (HALF - 8) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
    endtask

    task automatic txn(input logic [7:0] b, input logic par, input bit ack, input bit silent,
                       input int abort_k, input bit inject, input bit glitch);
        exp_t e;
        int   n;
        if (abort_k == 0) begin
            e.is_err    = (!ack) || silent;
            e.chk_frame = !silent;
            e.chk_tout  = silent;
            e.byte_v    = b;
            e.par       = par;
            sb.push_back(e);
            if (e.is_err) exp_err++;
            else exp_done++;
        end
        run_frame(b, ack, silent, abort_k, inject, glitch);
        n = 0;
        while (busy && (n < TOUT + 200)) begin
            @(negedge clk);
            n++;
        end
        chk("transfer_ended", {31'd0, busy}, 32'd0);
        repeat (10) @(negedge clk);
    endtask

    initial begin : global_guard
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin : stimulus
        repeat (3) @(negedge clk);
        chk("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        chk("reset_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        chk("reset_tx_done", {31'd0, tx_done}, 32'd0);
        chk("reset_tx_error", {31'd0, tx_error}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        //  byte   par   ack silent abort inject glitch
        txn(8'hED, 1'b1, 1, 0, 0, 0, 0);
        txn(8'hF4, 1'b0, 1, 0, 0, 0, 0);
        txn(8'h3C, 1'b1, 0, 0, 0, 0, 0);
        txn(8'hA5, 1'b1, 1, 1, 0, 0, 0);
        txn(8'h81, 1'b1, 1, 0, 0, 1, 0);
        txn(8'h12, 1'b1, 1, 0, 4, 0, 0);
        txn(8'hFF, 1'b1, 1, 0, 0, 0, 0);
`ifdef PS2_TX_GLITCH_FILTER_EN
        txn(8'h96, 1'b1, 1, 0, 0, 0, 1);
`endif

        repeat (20) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        chk("done_count", n_done, exp_done);
        chk("error_count", n_err, exp_err);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
